// File: rtl/lif_neuron_param.sv
// Parametrised leaky integrate-and-fire neuron: registered synaptic current stage feeding a
// membrane/refractory stage, with selectable post-fire reset and a saturating spike counter.
module lif_neuron_param #(
    parameter int M    = 8,
    parameter int WW   = 2,
    parameter int VW   = 6,
    parameter int CNTW = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [M-1:0]      input_spikes,
    input  logic [M*WW-1:0]   weights,
    input  logic [VW-1:0]     threshold,
    input  logic [VW-1:0]     decay,
    input  logic [VW-1:0]     refractory_period,
    input  logic              reset_mode,
    output logic [VW:0]       input_current_out,
    output logic [VW-1:0]     membrane_potential_out,
    output logic              refractory_active,
    output logic [CNTW-1:0]   spike_count,
    output logic              spike_out
);

    localparam int SW = WW + $clog2(M) + 1;
    // Accumulator is at least VW+2 wide so the saturation bounds are representable.
    localparam int XW = (SW > VW + 2) ? SW : VW + 2;

    logic signed [XW-1:0]   sum;
    logic signed [XW-1:0]   sat_max;
    logic signed [XW-1:0]   sat_min;
    logic signed [VW:0]     cur_sat;
    logic signed [VW:0]     cur_d, cur_q;
    logic [VW-1:0]          mem_d, mem_q;
    logic [VW-1:0]          refr_d, refr_q;
    logic [CNTW-1:0]        cnt_d, cnt_q;
    logic                   spike_d, spike_q;
    logic signed [VW+1:0]   v_next;
    logic [VW-1:0]          v_clamp;
    logic                   fire;

    always_comb begin
        sum = '0;
        for (int i = 0; i < M; i++) begin
            if (input_spikes[i]) begin
                sum = sum + {{(XW-WW){weights[i*WW+WW-1]}}, weights[i*WW +: WW]};
            end
        end
        sat_max = {{(XW-VW){1'b0}}, {VW{1'b1}}};
        sat_min = {{(XW-VW){1'b1}}, {VW{1'b0}}};
        if (sum > sat_max) begin
            cur_sat = {1'b0, {VW{1'b1}}};
        end else if (sum < sat_min) begin
            cur_sat = {1'b1, {VW{1'b0}}};
        end else begin
            cur_sat = sum[VW:0];
        end
    end

    always_comb begin
        v_next = {2'b00, mem_q} - {2'b00, decay} + {cur_q[VW], cur_q};
        if (v_next[VW+1]) begin
            v_clamp = '0;
        end else if (v_next[VW]) begin
            v_clamp = '1;
        end else begin
            v_clamp = v_next[VW-1:0];
        end
        fire = (v_clamp >= threshold);
    end

    always_comb begin
        cur_d   = cur_q;
        mem_d   = mem_q;
        refr_d  = refr_q;
        cnt_d   = cnt_q;
        spike_d = 1'b0;
        if (enable) begin
            cur_d = cur_sat;
            if (refr_q != '0) begin
                refr_d = refr_q - VW'(1);
                mem_d  = '0;
            end else if (fire) begin
                spike_d = 1'b1;
                refr_d  = refractory_period;
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNTW'(1);
                end
                mem_d = reset_mode ? (v_clamp - threshold) : '0;
            end else begin
                mem_d = v_clamp;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_q   <= '0;
            mem_q   <= '0;
            refr_q  <= '0;
            cnt_q   <= '0;
            spike_q <= 1'b0;
        end else begin
            cur_q   <= cur_d;
            mem_q   <= mem_d;
            refr_q  <= refr_d;
            cnt_q   <= cnt_d;
            spike_q <= spike_d;
        end
    end

    assign input_current_out      = cur_q;
    assign membrane_potential_out = mem_q;
    assign refractory_active      = (refr_q != '0);
    assign spike_count            = cnt_q;
    assign spike_out              = spike_q;

endmodule

// File: doc/lif_neuron_param.md
Name: lif_neuron_param

Overview:
Parametrised leaky integrate-and-fire neuron with a registered input-current stage and a membrane/refractory stage. Generalises the fixed 2-bit-weight, 6-bit-membrane neuron to configurable fan-in, weight width and membrane width. Adds a selectable post-fire reset mode, a saturating spike counter, and debug visibility of the current, membrane and refractory state. Instanced per neuron inside a layer; all neurons of a layer share one enable.

Parameters:
M, 8, number of input spikes and weights
WW, 2, weight width in bits, signed two's complement (WW >= 2)
VW, 6, membrane potential width in bits, unsigned
CNTW, 8, spike counter width

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous reset, active high
enable  input  1  advances both stages when high; all state holds when low
input_spikes  input  M  one bit per synapse
weights  input  M*WW  weight i at bits [i*WW +: WW], signed
threshold  input  VW  firing threshold, unsigned
decay  input  VW  leak subtracted per enabled update, unsigned
refractory_period  input  VW  number of enabled cycles to hold after a fire
reset_mode  input  1  0 = membrane to zero on fire, 1 = subtract threshold
input_current_out  output  VW+1  debug: registered current, saturated signed
membrane_potential_out  output  VW  debug: membrane register
refractory_active  output  1  high while refractory counter is nonzero
spike_count  output  CNTW  total fires since reset, saturating
spike_out  output  1  one-cycle fire pulse

Behaviour:
- Clock is clk; reset is synchronous and active-high. Reset takes priority over enable. On reset, current_reg, membrane, refractory counter, spike_count and spike_out all become 0, including mid-refractory or mid-integration.
- Stage 1, on an edge with enable=1:
  - sum = sum over i of (input_spikes[i] ? weights[i] : 0), computed signed at WW+clog2(M)+1 bits with no overflow.
  - current_reg is loaded with sum saturated to the signed VW+1 range [-2^VW, 2^VW-1].
- Stage 2, on the same edge with enable=1, using the current_reg value from before the edge:
  - Refractory (counter != 0): counter decrements by 1; membrane is forced to 0; spike_out=0; no integration.
  - Otherwise: v_next = membrane - decay + current_reg, computed signed at VW+2 bits, then clamped to [0, 2^VW-1].
  - If v_next >= threshold: spike_out=1; counter loads refractory_period; spike_count increments, sticking at 2^CNTW-1; membrane becomes 0 when reset_mode=0, or v_next - threshold when reset_mode=1.
  - Else: spike_out=0 and membrane becomes v_next.
- Latency: spikes sampled at enabled edge k affect the membrane and spike_out at enabled edge k+1.
- enable=0: all registers hold, except spike_out, which clears to 0, so it is a one-cycle pulse per enabled update.
- threshold=0: fires on every non-refractory enabled update.
- refractory_period=0: no refractory hold; the neuron may fire on consecutive updates.
- refractory_active is combinational: (counter != 0).
- Control inputs are sampled live each enabled cycle; no shadowing.

Test Plan:
- Reset: assert reset for 2 cycles with random inputs and enable=1 -> all outputs 0; deassert -> first update uses current_reg=0.
- Integrate/fire, zero reset: M=8, WW=2, VW=6, weights all +1, spikes=8'h0F, decay=0, threshold=20, reset_mode=0 -> membrane 4,8,12,16, then fire on the 5th update; membrane returns to 0 and spike_count=1.
- Subtract reset: same setup with threshold=10, reset_mode=1 -> membrane 4,8, then fire with membrane=2; the next update gives 6.
- Refractory: threshold=4, current=4, refractory_period=3 -> fire, then 3 enabled updates with membrane 0, refractory_active=1 and no fire, then fire again on the 5th update; period=0 -> fire every update.
- Clamping and decay: weights all -2 with spikes=8'hFF (current -16), decay=5 -> membrane stays 0. Membrane 60 with current +8, threshold=63 -> clamps to 63 and fires. current_reg saturates to +63 or -64 when WW=6 and all weights are extreme.
- Enable gating and mid-operation reset: drop enable for 4 cycles mid-integration -> membrane and counter hold, spike_out=0. Assert reset during refractory -> counter 0 on the next edge; spike_count saturation checked with CNTW=2 (stops at 3).
